// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl link bundle: rx, tx and sensor request/ack.
// master = the sequencer, slave = uart + sensor side.
interface uart_cmd_ctrl_if;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done;
  logic       o_Req;
  logic [7:0] o_Addr;
  logic [7:0] o_Cmd;
  logic       i_Ack;
  logic [7:0] i_Resp_Code;
  logic [7:0] i_Resp_Data;
  logic       o_Busy;

  modport master (
    input  i_Rx_DV,
    input  i_Rx_Byte,
    output o_Tx_DV,
    output o_Tx_Byte,
    input  i_Tx_Active,
    input  i_Tx_Done,
    output o_Req,
    output o_Addr,
    output o_Cmd,
    input  i_Ack,
    input  i_Resp_Code,
    input  i_Resp_Data,
    output o_Busy
  );

  modport slave (
    output i_Rx_DV,
    output i_Rx_Byte,
    input  o_Tx_DV,
    input  o_Tx_Byte,
    output i_Tx_Active,
    output i_Tx_Done,
    input  o_Req,
    input  o_Addr,
    input  o_Cmd,
    output i_Ack,
    output i_Resp_Code,
    output i_Resp_Data,
    input  o_Busy
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: 2-byte command frame in, req/ack out,
// 2-byte response serialised back over the uart tx.
module uart_cmd_ctrl #(
  parameter int CLKS_PER_BIT  = 457,
  parameter int IBYTE_TIMEOUT = 20 * CLKS_PER_BIT,
  parameter int RESP_TIMEOUT  = 2500000,
  parameter int N_SLOTS       = 32,
  parameter int TIMER_W       = 24
) (
  input logic              i_Clock,
  input logic              i_Rst_n,
  uart_cmd_ctrl_if.master  bus
);

  localparam logic [TIMER_W-1:0] IB_LAST =
    TIMER_W'(IBYTE_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] RESP_LAST =
    TIMER_W'(RESP_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] T_MAX = '1;
  localparam logic [TIMER_W-1:0] T_ONE = TIMER_W'(1);
  localparam logic [8:0] SLOTS = 9'(N_SLOTS);
  localparam logic [7:0] ERR_ADDR = 8'hE1;
  localparam logic [7:0] ERR_RESP = 8'hE2;

  typedef enum logic [2:0] {
    IDLE,
    GOT_ADDR,
    REQ,
    SEND0,
    WAIT0,
    SEND1,
    WAIT1
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_inc;
  logic [7:0]         data_q;
  logic               addr_ok;

  assign timer_inc = (timer == T_MAX) ? timer
                                      : timer + T_ONE;
  assign addr_ok = {1'b0, bus.o_Addr} < SLOTS;

  // frame sequencer; every output is a register of this block
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state         <= IDLE;
      timer         <= '0;
      data_q        <= 8'h00;
      bus.o_Tx_DV   <= 1'b0;
      bus.o_Tx_Byte <= 8'h00;
      bus.o_Req     <= 1'b0;
      bus.o_Addr    <= 8'h00;
      bus.o_Cmd     <= 8'h00;
      bus.o_Busy    <= 1'b0;
    end else begin
      bus.o_Tx_DV <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_Rx_DV) begin
            bus.o_Addr <= bus.i_Rx_Byte;
            timer      <= '0;
            bus.o_Busy <= 1'b1;
            state      <= GOT_ADDR;
          end
        end
        GOT_ADDR: begin
          if (bus.i_Rx_DV) begin
            bus.o_Cmd <= bus.i_Rx_Byte;
            timer     <= '0;
            if (addr_ok) begin
              bus.o_Req <= 1'b1;
              state     <= REQ;
            end else begin
              bus.o_Tx_Byte <= ERR_ADDR;
              data_q        <= 8'h00;
              state         <= SEND0;
            end
          end else if (timer == IB_LAST) begin
            bus.o_Busy <= 1'b0;
            state      <= IDLE;
          end else begin
            timer <= timer_inc;
          end
        end
        REQ: begin
          if (bus.i_Ack) begin
            bus.o_Req     <= 1'b0;
            bus.o_Tx_Byte <= bus.i_Resp_Code;
            data_q        <= bus.i_Resp_Data;
            state         <= SEND0;
          end else if (timer == RESP_LAST) begin
            bus.o_Req     <= 1'b0;
            bus.o_Tx_Byte <= ERR_RESP;
            data_q        <= 8'h00;
            state         <= SEND0;
          end else begin
            timer <= timer_inc;
          end
        end
        SEND0: begin
          if (!bus.i_Tx_Active) begin
            bus.o_Tx_DV <= 1'b1;
            state       <= WAIT0;
          end
        end
        WAIT0: begin
          if (bus.i_Tx_Done) begin
            bus.o_Tx_Byte <= data_q;
            state         <= SEND1;
          end
        end
        SEND1: begin
          if (!bus.i_Tx_Active) begin
            bus.o_Tx_DV <= 1'b1;
            state       <= WAIT1;
          end
        end
        WAIT1: begin
          if (bus.i_Tx_Done) begin
            bus.o_Busy <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          bus.o_Req  <= 1'b0;
          bus.o_Busy <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: random frames against a frame-level
// model, plus directed timeout, gating and reset cases.
module tb_uart_cmd_ctrl;

  localparam int IBT = 50;
  localparam int RT  = 100;
  localparam int NS  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if bus ();

  uart_cmd_ctrl #(
    .CLKS_PER_BIT (457),
    .IBYTE_TIMEOUT(IBT),
    .RESP_TIMEOUT (RT),
    .N_SLOTS      (NS),
    .TIMER_W      (24)
  ) dut (
    .i_Clock(clk),
    .i_Rst_n(rst_n),
    .bus    (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] tx_q[$];
  logic [7:0] tx_cur;
  int         tx_cnt = 0;
  int         tx_viol = 0;
  bit         tx_force = 1'b0;

  int         r_req;
  int         r_lat;
  logic [7:0] r_addr;
  logic [7:0] r_cmd;
  logic       r_busy;
  bit         r_hang;

  // transmitter model: 8-cycle byte, protocol watchdog
  initial begin
    bus.i_Tx_Active = 1'b0;
    bus.i_Tx_Done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_Tx_DV && bus.i_Tx_Active) tx_viol++;
      bus.i_Tx_Done = 1'b0;
      if (!rst_n) begin
        tx_cnt = 0;
      end else begin
        if (bus.o_Tx_DV) tx_q.push_back(bus.o_Tx_Byte);
        if (tx_cnt > 0) begin
          if (bus.o_Tx_Byte !== tx_cur) tx_viol++;
          tx_cnt--;
          if (tx_cnt == 0) bus.i_Tx_Done = 1'b1;
        end else if (bus.o_Tx_DV) begin
          tx_cur = bus.o_Tx_Byte;
          tx_cnt = 8;
        end
      end
      bus.i_Tx_Active = (tx_cnt > 0) || tx_force;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.i_Rx_Byte = b;
    bus.i_Rx_DV = 1'b1;
    @(negedge clk);
    bus.i_Rx_DV = 1'b0;
  endtask

  // drive one frame, record what the dut did
  task automatic do_frame(
    input logic [7:0] a, input logic [7:0] c,
    input int ack_at, input logic [7:0] code,
    input logic [7:0] data, input bit inject
  );
    int cyc;
    int nd;
    tx_q.delete();
    r_req = 0;
    r_lat = 0;
    r_addr = 8'hxx;
    r_cmd = 8'hxx;
    r_hang = 1'b0;
    send_byte(a);
    send_byte(c);
    cyc = 0;
    while (bus.o_Req && cyc < 1000) begin
      cyc++;
      r_req++;
      r_addr = bus.o_Addr;
      r_cmd = bus.o_Cmd;
      if (cyc == ack_at) begin
        bus.i_Ack = 1'b1;
        bus.i_Resp_Code = code;
        bus.i_Resp_Data = data;
      end
      if (inject && cyc == 2) begin
        bus.i_Rx_Byte = 8'h99;
        bus.i_Rx_DV = 1'b1;
      end
      @(negedge clk);
      bus.i_Ack = 1'b0;
      bus.i_Rx_DV = 1'b0;
    end
    while (!bus.o_Tx_DV && r_lat < 1000) begin
      @(negedge clk);
      r_lat++;
    end
    if (inject) begin
      @(negedge clk);
      send_byte(8'h99);
    end
    nd = 0;
    cyc = 0;
    while (nd < 2 && cyc < 3000) begin
      @(posedge clk);
      if (bus.i_Tx_Done) nd++;
      cyc++;
    end
    if (nd < 2) r_hang = 1'b1;
    @(negedge clk);
    r_busy = bus.o_Busy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_total++;
    if (bus.o_Busy !== 1'b0 || bus.o_Req !== 1'b0) begin
      $display("FAIL reset_ctl: busy=%b req=%b want 0 0",
               bus.o_Busy, bus.o_Req);
    end else n_pass++;
    n_total++;
    if ({bus.o_Tx_DV, bus.o_Tx_Byte} !== 9'h0) begin
      $display("FAIL reset_tx: dv=%b byte=%h want 0 00",
               bus.o_Tx_DV, bus.o_Tx_Byte);
    end else n_pass++;
    n_total++;
    if ({bus.o_Addr, bus.o_Cmd} !== 16'h0) begin
      $display("FAIL reset_ac: addr=%h cmd=%h want 00 00",
               bus.o_Addr, bus.o_Cmd);
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal;
    do_frame(8'h03, 8'h10, 5, 8'h00, 8'h2A, 1'b0);
    n_total++;
    if (r_hang) $display("FAIL norm_hang: got hang want done");
    else n_pass++;
    n_total++;
    if (r_req !== 5) $display("FAIL norm_req: got %0d want 5", r_req);
    else n_pass++;
    n_total++;
    if (r_addr !== 8'h03 || r_cmd !== 8'h10) begin
      $display("FAIL norm_ac: got %h %h want 03 10",
               r_addr, r_cmd);
    end else n_pass++;
    n_total++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'h00 ||
        tx_q[1] !== 8'h2A) begin
      $display("FAIL norm_tx: got %p want 00 2a", tx_q);
    end else n_pass++;
    n_total++;
    if (r_lat !== 1) $display("FAIL norm_lat: got %0d want 1", r_lat);
    else n_pass++;
    n_total++;
    if (r_busy !== 1'b0) $display("FAIL norm_busy: got %b want 0", r_busy);
    else n_pass++;
  endtask

  task automatic test_invalid;
    do_frame(8'h40, 8'h01, 1, 8'h55, 8'h66, 1'b0);
    n_total++;
    if (r_req !== 0) $display("FAIL inv_req: got %0d want 0", r_req);
    else n_pass++;
    n_total++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'hE1 ||
        tx_q[1] !== 8'h00) begin
      $display("FAIL inv_tx: got %p want e1 00", tx_q);
    end else n_pass++;
    n_total++;
    if (r_lat !== 1) $display("FAIL inv_lat: got %0d want 1", r_lat);
    else n_pass++;
    // boundary: address N_SLOTS-1 is still valid
    do_frame(8'h1F, 8'h02, 2, 8'h07, 8'h08, 1'b0);
    n_total++;
    if (r_req !== 2 || tx_q.size() != 2 || tx_q[0] !== 8'h07) begin
      $display("FAIL inv_edge: got req=%0d tx=%p want 2 07 08",
               r_req, tx_q);
    end else n_pass++;
  endtask

  task automatic test_resp_timeout;
    do_frame(8'h0A, 8'h11, 0, 8'h00, 8'h00, 1'b0);
    n_total++;
    if (r_req !== RT) $display("FAIL rto_req: got %0d want %0d", r_req, RT);
    else n_pass++;
    n_total++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'hE2 ||
        tx_q[1] !== 8'h00) begin
      $display("FAIL rto_tx: got %p want e2 00", tx_q);
    end else n_pass++;
    do_frame(8'h0B, 8'h12, RT, 8'h5A, 8'hC3, 1'b0);
    n_total++;
    if (r_req !== RT) $display("FAIL race_req: got %0d want %0d", r_req, RT);
    else n_pass++;
    n_total++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'h5A ||
        tx_q[1] !== 8'hC3) begin
      $display("FAIL race_tx: got %p want 5a c3", tx_q);
    end else n_pass++;
  endtask

  task automatic test_ibyte_timeout;
    tx_q.delete();
    send_byte(8'h05);
    repeat (IBT - 1) @(negedge clk);
    n_total++;
    if (bus.o_Busy !== 1'b1) begin
      $display("FAIL ibt_hold: got busy=%b want 1", bus.o_Busy);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.o_Busy !== 1'b0) begin
      $display("FAIL ibt_drop: got busy=%b want 0", bus.o_Busy);
    end else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (tx_q.size() != 0) $display("FAIL ibt_stray: got %p want empty", tx_q);
    else n_pass++;
    do_frame(8'h07, 8'h20, 3, 8'h01, 8'h02, 1'b0);
    n_total++;
    if (r_addr !== 8'h07 || r_cmd !== 8'h20 || r_req !== 3) begin
      $display("FAIL ibt_next: got %h %h %0d want 07 20 3",
               r_addr, r_cmd, r_req);
    end else n_pass++;
  endtask

  task automatic test_ignore_rx;
    do_frame(8'h04, 8'h22, 10, 8'h11, 8'h77, 1'b1);
    n_total++;
    if (tx_q.size() != 2 || tx_q[0] !== 8'h11 ||
        tx_q[1] !== 8'h77 || r_req !== 10) begin
      $display("FAIL ign_tx: got %p req=%0d want 11 77 10",
               tx_q, r_req);
    end else n_pass++;
    n_total++;
    if (r_addr !== 8'h04 || r_cmd !== 8'h22) begin
      $display("FAIL ign_ac: got %h %h want 04 22", r_addr, r_cmd);
    end else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if (bus.o_Busy !== 1'b0 || bus.o_Addr !== 8'h04) begin
      $display("FAIL ign_idle: got busy=%b addr=%h want 0 04",
               bus.o_Busy, bus.o_Addr);
    end else n_pass++;
  endtask

  task automatic test_tx_gating;
    int w;
    tx_force = 1'b1;
    repeat (2) @(negedge clk);
    tx_q.delete();
    send_byte(8'h01);
    send_byte(8'h44);
    bus.i_Ack = 1'b1;
    bus.i_Resp_Code = 8'h3C;
    bus.i_Resp_Data = 8'h5D;
    @(negedge clk);
    bus.i_Ack = 1'b0;
    repeat (10) @(negedge clk);
    n_total++;
    if (tx_q.size() != 0) $display("FAIL gate_hold: got %p want empty", tx_q);
    else n_pass++;
    tx_force = 1'b0;
    w = 0;
    while (tx_q.size() == 0 && w < 6) begin
      @(negedge clk);
      w++;
    end
    n_total++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h3C) begin
      $display("FAIL gate_rel: got %p want 3c", tx_q);
    end else n_pass++;
    w = 0;
    while (bus.o_Busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_total++;
    if (tx_q.size() != 2 || tx_q[1] !== 8'h5D || bus.o_Busy) begin
      $display("FAIL gate_done: got %p busy=%b want 3c 5d 0",
               tx_q, bus.o_Busy);
    end else n_pass++;
  endtask

  task automatic test_reset_mid;
    int w;
    send_byte(8'h02);
    send_byte(8'h09);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.o_Req, bus.o_Busy, bus.o_Tx_DV, bus.o_Tx_Byte,
         bus.o_Addr, bus.o_Cmd} !== 27'h0) begin
      $display("FAIL rst_req: req=%b busy=%b addr=%h want all 0",
               bus.o_Req, bus.o_Busy, bus.o_Addr);
    end else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_frame(8'h06, 8'h31, 4, 8'h01, 8'h02, 1'b0);
    n_total++;
    if (r_hang || r_req !== 4 || tx_q.size() != 2 ||
        tx_q[0] !== 8'h01 || tx_q[1] !== 8'h02) begin
      $display("FAIL rst_req_next: got req=%0d tx=%p want 4 01 02",
               r_req, tx_q);
    end else n_pass++;
    send_byte(8'h50);
    send_byte(8'h01);
    w = 0;
    while (!bus.o_Tx_DV && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.o_Req, bus.o_Busy, bus.o_Tx_DV, bus.o_Tx_Byte,
         bus.o_Addr, bus.o_Cmd} !== 27'h0) begin
      $display("FAIL rst_wait0: busy=%b byte=%h addr=%h want all 0",
               bus.o_Busy, bus.o_Tx_Byte, bus.o_Addr);
    end else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_frame(8'h08, 8'h32, 6, 8'hA0, 8'hB0, 1'b0);
    n_total++;
    if (r_hang || r_req !== 6 || tx_q.size() != 2 ||
        tx_q[0] !== 8'hA0 || tx_q[1] !== 8'hB0) begin
      $display("FAIL rst_w0_next: got req=%0d tx=%p want 6 a0 b0",
               r_req, tx_q);
    end else n_pass++;
  endtask

  // frame-level model: address range decides the path,
  // the ack cycle decides real response versus 0xe2
  task automatic test_random;
    logic [7:0] a, c, code, data, e0, e1;
    int ack_at, e_req;
    bit ok;
    for (int i = 0; i < 25; i++) begin
      a = 8'($urandom_range(0, 47));
      c = 8'($urandom);
      code = 8'($urandom);
      data = 8'($urandom);
      ack_at = $urandom_range(0, 110);
      if (a >= NS) begin
        e_req = 0;
        e0 = 8'hE1;
        e1 = 8'h00;
      end else if (ack_at >= 1 && ack_at <= RT) begin
        e_req = ack_at;
        e0 = code;
        e1 = data;
      end else begin
        e_req = RT;
        e0 = 8'hE2;
        e1 = 8'h00;
      end
      do_frame(a, c, ack_at, code, data, 1'b0);
      n_total++;
      if (r_req !== e_req) begin
        $display("FAIL rnd_req[%0d]: got %0d want %0d",
                 i, r_req, e_req);
      end else n_pass++;
      ok = tx_q.size() == 2;
      if (ok) ok = (tx_q[0] === e0) && (tx_q[1] === e1);
      n_total++;
      if (!ok || r_hang || r_busy !== 1'b0) begin
        $display("FAIL rnd_tx[%0d]: got %p busy=%b want %h %h 0",
                 i, tx_q, r_busy, e0, e1);
      end else n_pass++;
      if (e_req > 0) begin
        n_total++;
        if (r_addr !== a || r_cmd !== c) begin
          $display("FAIL rnd_ac[%0d]: got %h %h want %h %h",
                   i, r_addr, r_cmd, a, c);
        end else n_pass++;
      end
    end
    n_total++;
    if (tx_viol !== 0) $display("FAIL tx_proto: got %0d want 0", tx_viol);
    else n_pass++;
  endtask

  initial begin
    bus.i_Rx_DV = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    bus.i_Ack = 1'b0;
    bus.i_Resp_Code = 8'h00;
    bus.i_Resp_Data = 8'h00;
    test_reset();
    test_normal();
    test_invalid();
    test_resp_timeout();
    test_ibyte_timeout();
    test_ignore_rx();
    test_tx_gating();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer between the UART receiver and transmitter. It collects a 2-byte command frame (address, opcode) from the receiver and dispatches it as a request/acknowledge transaction to the sensor-side logic. It then serialises the 2-byte response (status code, data) back through the transmitter. It owns all timing of the serial link: inter-byte timeout, response timeout and transmitter handshaking.

## Interface
- CLKS_PER_BIT, 457: UART bit period in clocks; informational only, sets the default IBYTE_TIMEOUT.
- IBYTE_TIMEOUT, 20*457: max clocks between address byte and opcode byte.
- RESP_TIMEOUT, 2500000: max clocks from o_Req rise to i_Ack.
- N_SLOTS, 32: valid addresses are 0..N_SLOTS-1 (N_SLOTS ≤ 256).
- TIMER_W, 24: timer width; must hold max(IBYTE_TIMEOUT, RESP_TIMEOUT).

Ports:
- i_Clock  in  1  system clock, all logic on rising edge
- i_Rst_n  in  1  asynchronous, active-low reset
- i_Rx_DV  in  1  one-cycle pulse, i_Rx_Byte valid
- i_Rx_Byte  in  8  received byte
- o_Tx_DV  out  1  one-cycle pulse, start transmission of o_Tx_Byte
- o_Tx_Byte  out  8  byte to transmit; stable from o_Tx_DV until i_Tx_Done
- i_Tx_Active  in  1  transmitter busy
- i_Tx_Done  in  1  one-cycle pulse, byte fully sent
- o_Req  out  1  level request to sensor logic
- o_Addr  out  8  latched address, valid while o_Req=1
- o_Cmd  out  8  latched opcode, valid while o_Req=1
- i_Ack  in  1  one-cycle pulse, response valid
- i_Resp_Code  in  8  status code, sampled with i_Ack
- i_Resp_Data  in  8  data byte, sampled with i_Ack
- o_Busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, GOT_ADDR, REQ, SEND0, WAIT0, SEND1, WAIT1.
- IDLE: on i_Rx_DV, latch the byte to o_Addr, clear the timer, go to GOT_ADDR.
- GOT_ADDR: on i_Rx_DV, latch the byte to o_Cmd.
  - If o_Addr < N_SLOTS: go to REQ.
  - Otherwise: load code 0xE1 and data 0x00, go to SEND0.
  - If the timer reaches IBYTE_TIMEOUT-1 with no byte: return to IDLE silently and discard the address.
- REQ: o_Req=1, timer counts.
  - On i_Ack: latch code and data, drop o_Req, go to SEND0.
  - If the timer reaches RESP_TIMEOUT-1 with no ack: load 0xE2/0x00, drop o_Req, go to SEND0.
  - i_Ack in the same cycle as the timeout: ack wins.
- SEND0: drive o_Tx_Byte=code. In the first cycle with i_Tx_Active=0, pulse o_Tx_DV for exactly one cycle and go to WAIT0.
- WAIT0: on i_Tx_Done, go to SEND1.
- SEND1/WAIT1: same as SEND0/WAIT0 with the data byte; WAIT1 returns to IDLE on i_Tx_Done.
- i_Rx_DV in any state other than IDLE/GOT_ADDR: byte ignored (no queuing).
- i_Ack outside REQ: ignored.
- Timer width: TIMER_W; saturates, never wraps.

## Timing
- Reset (async assert, sync release): state=IDLE; o_Tx_DV=0, o_Tx_Byte=0x00, o_Req=0, o_Addr=0x00, o_Cmd=0x00, o_Busy=0; timer=0.
- Reset mid-transaction: immediate abort; no partial frame or pending response survives.
- All outputs are registered. An event sampled at edge k produces its output change after edge k.
- Opcode i_Rx_DV at edge k: o_Req=1 from edge k.
- Invalid address: o_Tx_DV at edge k+1 at the earliest.
- i_Ack at edge k: o_Req=0 from edge k. o_Tx_DV high for cycle k+1 if i_Tx_Active=0.
- i_Tx_Done for byte 0 at edge m: o_Tx_DV for byte 1 at edge m+1 at the earliest (gated by i_Tx_Active=0).
- i_Tx_Done for byte 1 at edge m: o_Busy=0 from edge m.
- o_Tx_DV never asserts while i_Tx_Active=1; never more than one pulse per byte.

## Test plan
- Normal transaction: send 0x03, 0x10. Expect o_Req=1 with o_Addr=0x03 and o_Cmd=0x10. Ack with code 0x00, data 0x2A. Expect two o_Tx_DV pulses carrying 0x00 then 0x2A, o_Busy low after the second i_Tx_Done.
- Invalid address: send 0x40, 0x01 with N_SLOTS=32. Expect o_Req to stay 0 and TX bytes 0xE1, 0x00.
- Response timeout: RESP_TIMEOUT=100, no ack. Expect o_Req high for exactly 100 cycles, then TX bytes 0xE2, 0x00. Repeat with i_Ack on cycle 100: expect the real code/data.
- Inter-byte timeout: send 0x05 only, wait IBYTE_TIMEOUT cycles. Then send 0x07, 0x20. Expect o_Addr=0x07 and o_Cmd=0x20, with no stray TX.
- Busy drop and TX gating: inject i_Rx_DV 0x99 during REQ and WAIT0; expect it ignored. Hold i_Tx_Active=1 on entry to SEND0; expect o_Tx_DV delayed until it falls.
- Reset mid-REQ and mid-WAIT0: assert i_Rst_n=0. Expect all outputs to return to their reset values immediately and the next frame to be handled normally.
